// File: rtl/motoro301_pkg.sv
// Shared definitions for the motoro301 ramp controller: FSM state codes,
// default parameter values and the saturating frequency-step helpers.
package motoro301_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RAMP_UP   = 3'd1,
    ST_RUN       = 3'd2,
    ST_RAMP_DOWN = 3'd3,
    ST_DEAD      = 3'd4
  } state_t;

  localparam int         DEF_TICK_DIV   = 50000;
  localparam logic [9:0] DEF_FREQ_MIN   = 10'd16;
  localparam logic [9:0] DEF_STEP       = 10'd1;
  localparam int         DEF_DEAD_TICKS = 100;

  // One step up, clamped to lim; 11-bit sum so a large inc cannot wrap.
  function automatic logic [9:0] freq_step_up(input logic [9:0] cur,
                                              input logic [9:0] inc,
                                              input logic [9:0] lim);
    logic [10:0] sum;
    sum = {1'b0, cur} + {1'b0, inc};
    return (sum >= {1'b0, lim}) ? lim : sum[9:0];
  endfunction

  // One step down, clamped to flr; bit 10 of the difference flags underflow.
  function automatic logic [9:0] freq_step_down(input logic [9:0] cur,
                                                input logic [9:0] dec,
                                                input logic [9:0] flr);
    logic [10:0] diff;
    diff = {1'b0, cur} - {1'b0, dec};
    return (diff[10] || (diff[9:0] <= flr)) ? flr : diff[9:0];
  endfunction

endpackage

// File: rtl/motoro301_tick_div.sv
// Clearable prescaler producing a one-cycle tick every TICK_DIV enabled cycles.
// clr marks the first cycle of a new state: that cycle counts as zero, so the
// first tick after a state entry lands exactly TICK_DIV-1 cycles into the state.
module motoro301_tick_div
  import motoro301_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_cur;

  assign cnt_cur = clr ? '0 : cnt_reg;
  assign tick    = en && (cnt_cur == LAST);

  // Free-running modulo-TICK_DIV count while enabled, restarted by clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= (cnt_cur == LAST) ? '0 : cnt_cur + CW'(1);
    end else begin
      cnt_reg <= cnt_cur;
    end
  end

endmodule

// File: rtl/motoro301_ramp_ctrl.sv
// Motor ramp controller: soft start/stop, speed retargeting and direction
// reversal through a coast (DEAD) interval, driving a 3-phase driver.
module motoro301_ramp_ctrl
  import motoro301_pkg::*;
#(
  parameter int         TICK_DIV   = DEF_TICK_DIV,
  parameter logic [9:0] FREQ_MIN   = DEF_FREQ_MIN,
  parameter logic [9:0] STEP       = DEF_STEP,
  parameter int         DEAD_TICKS = DEF_DEAD_TICKS
) (
  input  logic       clk50mhz,
  input  logic       nReset,
  input  logic       cmdStart,
  input  logic       cmdStop,
  input  logic       cmdDir,
  input  logic [9:0] tgtFreq,
  input  logic       fault,
  output logic       m3start,
  output logic       m3invOrStop,
  output logic [9:0] m3freq,
  output logic       atSpeed,
  output logic       busy,
  output logic [2:0] state
);

  localparam int            DW        = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;
  localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_TICKS - 1);

  state_t        state_reg;
  logic [9:0]    target_reg;
  logic          stop_pend_reg;
  logic          rev_pend_reg;
  logic          rev_dir_reg;
  logic [DW-1:0] dead_cnt_reg;
  logic          entered_reg;

  logic          tick;
  logic          prescale_en;
  logic [9:0]    tgt_clamp;
  logic [9:0]    down_floor;
  logic [9:0]    freq_up;
  logic [9:0]    freq_down;
  logic          dead_last;

  assign state       = state_reg;
  assign prescale_en = (state_reg == ST_RAMP_UP) || (state_reg == ST_RAMP_DOWN) ||
                       (state_reg == ST_DEAD);
  assign tgt_clamp   = (tgtFreq < FREQ_MIN) ? FREQ_MIN : tgtFreq;
  // A pending stop or reversal ramps all the way down; a plain retarget stops at target.
  assign down_floor  = (stop_pend_reg || rev_pend_reg) ? FREQ_MIN : target_reg;
  assign freq_up     = freq_step_up(m3freq, STEP, target_reg);
  assign freq_down   = freq_step_down(m3freq, STEP, down_floor);
  assign dead_last   = (dead_cnt_reg == DEAD_LAST);

  motoro301_tick_div #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_div (
    .clk  (clk50mhz),
    .rst_n(nReset),
    .clr  (entered_reg),
    .en   (prescale_en),
    .tick (tick)
  );

  // Ramp FSM; every output is a flop so commands show up one cycle later.
  always_ff @(posedge clk50mhz or negedge nReset) begin
    if (!nReset) begin
      state_reg     <= ST_IDLE;
      m3start       <= 1'b0;
      m3invOrStop   <= 1'b0;
      m3freq        <= '0;
      atSpeed       <= 1'b0;
      busy          <= 1'b0;
      target_reg    <= '0;
      stop_pend_reg <= 1'b0;
      rev_pend_reg  <= 1'b0;
      rev_dir_reg   <= 1'b0;
      dead_cnt_reg  <= '0;
      entered_reg   <= 1'b0;
    end else begin
      entered_reg <= 1'b0;
      if (fault && (state_reg != ST_IDLE) && (state_reg != ST_DEAD)) begin
        // Fault overrides everything: drop the drive and coast, forgetting any reversal.
        state_reg     <= ST_DEAD;
        entered_reg   <= 1'b1;
        m3start       <= 1'b0;
        m3freq        <= '0;
        atSpeed       <= 1'b0;
        stop_pend_reg <= 1'b0;
        rev_pend_reg  <= 1'b0;
        dead_cnt_reg  <= '0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (cmdStart && !cmdStop && !fault) begin
              state_reg     <= ST_RAMP_UP;
              entered_reg   <= 1'b1;
              m3start       <= 1'b1;
              m3freq        <= FREQ_MIN;
              m3invOrStop   <= cmdDir;
              target_reg    <= tgt_clamp;
              busy          <= 1'b1;
              stop_pend_reg <= 1'b0;
              rev_pend_reg  <= 1'b0;
            end
          end

          ST_RAMP_UP: begin
            if (cmdStop) begin
              state_reg     <= ST_RAMP_DOWN;
              entered_reg   <= 1'b1;
              stop_pend_reg <= 1'b1;
            end else if (m3freq >= target_reg) begin
              state_reg   <= ST_RUN;
              entered_reg <= 1'b1;
              atSpeed     <= 1'b1;
            end else if (tick) begin
              m3freq <= freq_up;
            end
          end

          ST_RUN: begin
            target_reg <= tgt_clamp;
            if (cmdStop) begin
              state_reg     <= ST_RAMP_DOWN;
              entered_reg   <= 1'b1;
              atSpeed       <= 1'b0;
              stop_pend_reg <= 1'b1;
            end else if (cmdDir != m3invOrStop) begin
              // New direction is parked until the coast, where m3start is low.
              state_reg    <= ST_RAMP_DOWN;
              entered_reg  <= 1'b1;
              atSpeed      <= 1'b0;
              rev_pend_reg <= 1'b1;
              rev_dir_reg  <= cmdDir;
            end else if (tgt_clamp > m3freq) begin
              state_reg   <= ST_RAMP_UP;
              entered_reg <= 1'b1;
              atSpeed     <= 1'b0;
            end else if (tgt_clamp < m3freq) begin
              state_reg   <= ST_RAMP_DOWN;
              entered_reg <= 1'b1;
              atSpeed     <= 1'b0;
            end
          end

          ST_RAMP_DOWN: begin
            if (cmdStop) begin
              stop_pend_reg <= 1'b1;
            end else if (cmdStart) begin
              state_reg     <= ST_RAMP_UP;
              entered_reg   <= 1'b1;
              target_reg    <= tgt_clamp;
              stop_pend_reg <= 1'b0;
              rev_pend_reg  <= 1'b0;
            end else if (m3freq <= down_floor) begin
              entered_reg <= 1'b1;
              if (stop_pend_reg || rev_pend_reg) begin
                state_reg    <= ST_DEAD;
                m3start      <= 1'b0;
                m3freq       <= '0;
                dead_cnt_reg <= '0;
              end else begin
                state_reg <= ST_RUN;
                atSpeed   <= 1'b1;
              end
            end else if (tick) begin
              m3freq <= freq_down;
            end
          end

          ST_DEAD: begin
            if (fault) begin
              rev_pend_reg <= 1'b0;
            end
            // m3start is low for the whole coast, so the direction is safe to change here.
            if (rev_pend_reg) begin
              m3invOrStop <= rev_dir_reg;
            end
            if (tick) begin
              if (!dead_last) begin
                dead_cnt_reg <= dead_cnt_reg + DW'(1);
              end else if (!fault) begin
                dead_cnt_reg  <= '0;
                entered_reg   <= 1'b1;
                stop_pend_reg <= 1'b0;
                if (rev_pend_reg) begin
                  state_reg    <= ST_RAMP_UP;
                  m3start      <= 1'b1;
                  m3freq       <= FREQ_MIN;
                  rev_pend_reg <= 1'b0;
                end else begin
                  state_reg <= ST_IDLE;
                  busy      <= 1'b0;
                end
              end
            end
          end

          default: begin
            state_reg   <= ST_IDLE;
            entered_reg <= 1'b1;
            m3start     <= 1'b0;
            m3freq      <= '0;
            atSpeed     <= 1'b0;
            busy        <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_motoro301_ramp_ctrl.sv
// Directed bench for motoro301_ramp_ctrl with a frequency-change scoreboard:
// each expected m3freq value (and, where known, its spacing in cycles) is
// queued as stimulus is driven and popped whenever m3freq changes.
module tb_motoro301_ramp_ctrl;

  logic       clk50mhz = 1'b0;
  logic       nReset   = 1'b0;
  logic       cmdStart = 1'b0;
  logic       cmdStop  = 1'b0;
  logic       cmdDir   = 1'b0;
  logic [9:0] tgtFreq  = '0;
  logic       fault    = 1'b0;
  logic       m3start;
  logic       m3invOrStop;
  logic [9:0] m3freq;
  logic       atSpeed;
  logic       busy;
  logic [2:0] state;

  typedef struct {
    int freq;
    int gap;
  } exp_t;

  exp_t       sb[$];
  int         passed      = 0;
  int         total       = 0;
  int         cyc         = 0;
  int         last_chg    = 0;
  int         start_drops = 0;
  logic [9:0] last_freq   = '0;
  logic       prev_start  = 1'b0;
  logic       prev_inv    = 1'b0;

  motoro301_ramp_ctrl #(
    .TICK_DIV  (4),
    .FREQ_MIN  (10'd2),
    .STEP      (10'd1),
    .DEAD_TICKS(3)
  ) dut (
    .clk50mhz   (clk50mhz),
    .nReset     (nReset),
    .cmdStart   (cmdStart),
    .cmdStop    (cmdStop),
    .cmdDir     (cmdDir),
    .tgtFreq    (tgtFreq),
    .fault      (fault),
    .m3start    (m3start),
    .m3invOrStop(m3invOrStop),
    .m3freq     (m3freq),
    .atSpeed    (atSpeed),
    .busy       (busy),
    .state      (state)
  );

  always #5 clk50mhz = ~clk50mhz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic push(input int f, input int g);
    sb.push_back('{f, g});
  endtask

  // One clock; sample on the falling edge and score any m3freq change.
  task automatic step();
    exp_t e;
    int   gap;
    @(negedge clk50mhz);
    cyc++;
    if (prev_start && m3start) chk("dir_stable_while_running", m3invOrStop, prev_inv);
    if (prev_start && !m3start) start_drops++;
    if (m3freq !== last_freq) begin
      gap = cyc - last_chg;
      chk("expected_change", (sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("freq_value", m3freq, e.freq);
        if (e.gap != 0) chk("freq_gap", gap, e.gap);
      end
      $display("cycle %0d: m3freq %0d state %0d m3start %0d dir %0d", cyc, m3freq, state,
               m3start, m3invOrStop);
      last_freq = m3freq;
      last_chg  = cyc;
    end
    prev_start = m3start;
    prev_inv   = m3invOrStop;
  endtask

  task automatic start_cmd();
    cmdStart = 1'b1;
    step();
    cmdStart = 1'b0;
  endtask

  task automatic stop_cmd();
    cmdStop = 1'b1;
    step();
    cmdStop = 1'b0;
  endtask

  task automatic wait_state(input int s, input int budget, input string tag);
    int n = 0;
    while (state !== s[2:0] && n < budget) begin
      step();
      n++;
    end
    chk(tag, state, s);
  endtask

  task automatic drain(input int budget, input string tag);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin
      step();
      n++;
    end
    chk(tag, sb.size(), 0);
  endtask

  task automatic ramp_to_six();
    push(2, 0); push(3, 4); push(4, 4); push(5, 4); push(6, 4);
  endtask

  initial begin
    int n;
    int drops0;

    // Reset state
    repeat (3) @(negedge clk50mhz);
    chk("rst_m3start", m3start, 0);
    chk("rst_dir", m3invOrStop, 0);
    chk("rst_freq", m3freq, 0);
    chk("rst_atspeed", atSpeed, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", state, 0);
    nReset = 1'b1;
    step(); step();
    chk("idle_hold", state, 0);

    // Soft start to 6, forward
    tgtFreq = 10'd6;
    cmdDir  = 1'b0;
    ramp_to_six();
    start_cmd();
    chk("start_m3start", m3start, 1);
    chk("start_busy", busy, 1);
    chk("start_state", state, 1);
    drain(40, "rampup_drain");
    wait_state(2, 5, "run_reached");
    chk("run_atspeed", atSpeed, 1);
    chk("run_dir", m3invOrStop, 0);

    // Stop: ramp down to 2, 12-cycle coast, then idle
    push(5, 0); push(4, 4); push(3, 4); push(2, 4); push(0, 1);
    stop_cmd();
    chk("stop_state", state, 3);
    chk("stop_atspeed", atSpeed, 0);
    drain(40, "rampdown_drain");
    chk("dead_state", state, 4);
    chk("dead_m3start", m3start, 0);
    n = 1;
    while (state === 3'd4 && n < 50) begin
      step();
      if (state === 3'd4) n++;
    end
    chk("dead_length", n, 12);
    chk("after_dead_state", state, 0);
    chk("after_dead_busy", busy, 0);

    // Reversal from RUN at 6
    ramp_to_six();
    start_cmd();
    drain(40, "rampup2_drain");
    wait_state(2, 5, "run2_reached");
    cmdDir = 1'b1;
    push(5, 0); push(4, 4); push(3, 4); push(2, 4); push(0, 1);
    push(2, 12); push(3, 4); push(4, 4); push(5, 4); push(6, 4);
    step();
    chk("rev_state", state, 3);
    chk("rev_dir_held", m3invOrStop, 0);
    drain(100, "reverse_drain");
    chk("rev_dir_applied", m3invOrStop, 1);
    wait_state(2, 5, "run3_reached");
    chk("run3_atspeed", atSpeed, 1);

    // Retarget down to 3 without dropping m3start
    drops0  = start_drops;
    tgtFreq = 10'd3;
    push(5, 0); push(4, 4); push(3, 4);
    step();
    chk("retarget_state", state, 3);
    drain(30, "retarget_drain");
    wait_state(2, 5, "retarget_run");
    chk("retarget_freq", m3freq, 3);
    chk("retarget_no_drop", start_drops - drops0, 0);

    push(2, 0); push(0, 1);
    stop_cmd();
    drain(30, "stop2_drain");
    wait_state(0, 30, "stop2_idle");

    // Start and stop together in IDLE: stop wins
    cmdStart = 1'b1;
    cmdStop  = 1'b1;
    step();
    cmdStart = 1'b0;
    cmdStop  = 1'b0;
    chk("startstop_state", state, 0);
    chk("startstop_m3start", m3start, 0);
    step();
    chk("startstop_busy", busy, 0);

    // tgtFreq=0 clamps to FREQ_MIN
    tgtFreq = 10'd0;
    push(2, 0);
    start_cmd();
    chk("clamp_rampup", state, 1);
    step();
    chk("clamp_run", state, 2);
    chk("clamp_freq", m3freq, 2);
    chk("clamp_atspeed", atSpeed, 1);
    push(0, 0);
    stop_cmd();
    drain(20, "clamp_stop_drain");
    wait_state(0, 30, "clamp_idle");

    // Fault at m3freq=4 forces coast, held while fault stays high
    cmdDir  = 1'b0;
    tgtFreq = 10'd6;
    push(2, 0); push(3, 4); push(4, 4);
    start_cmd();
    drain(30, "fault_ramp_drain");
    fault = 1'b1;
    push(0, 0);
    step();
    chk("fault_m3start", m3start, 0);
    chk("fault_state", state, 4);
    n = 0;
    repeat (20) begin
      step();
      if (state !== 3'd4) n++;
    end
    chk("fault_dead_held", n, 0);
    fault = 1'b0;
    wait_state(0, 40, "fault_release_idle");
    chk("fault_release_busy", busy, 0);

    // Asynchronous reset mid ramp-up
    push(2, 0); push(3, 4);
    start_cmd();
    drain(20, "reset_ramp_drain");
    step(); step();
    #2 nReset = 1'b0;
    #1;
    chk("async_rst_m3start", m3start, 0);
    chk("async_rst_freq", m3freq, 0);
    chk("async_rst_state", state, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_dir", m3invOrStop, 0);
    @(negedge clk50mhz);
    nReset     = 1'b1;
    last_freq  = '0;
    last_chg   = cyc;
    prev_start = 1'b0;
    prev_inv   = m3invOrStop;
    repeat (5) step();
    chk("post_reset_idle", state, 0);
    chk("post_reset_m3start", m3start, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/motoro301_ramp_ctrl.md
MOTORO301_RAMP_CTRL -- requirements
Module: motoro301_ramp_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000, clk50mhz cycles per ramp tick (1 ms).
REQ-002 SHALL have parameter FREQ_MIN, default 10'd16, minimum non-zero m3freq and start frequency.
REQ-003 SHALL have parameter STEP, default 10'd1, m3freq change per ramp tick.
REQ-004 SHALL have parameter DEAD_TICKS, default 100, coast ticks before a restart or return to idle.
REQ-005 SHALL have port clk50mhz  in  1  sole clock, 50 MHz.
REQ-006 SHALL have port nReset  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port cmdStart  in  1  one-cycle start request.
REQ-008 SHALL have port cmdStop  in  1  one-cycle stop request.
REQ-009 SHALL have port cmdDir  in  1  requested direction, 1 = reverse.
REQ-010 SHALL have port tgtFreq  in  10  requested run frequency.
REQ-011 SHALL have port fault  in  1  level, forces immediate coast.
REQ-012 SHALL have port m3start  out  1  motor enable to the 3-phase driver.
REQ-013 SHALL have port m3invOrStop  out  1  latched direction to the driver.
REQ-014 SHALL have port m3freq  out  10  commanded frequency to the driver.
REQ-015 SHALL have ports atSpeed  out  1, busy  out  1, and state  out  3 (FSM code).

Function
REQ-016 SHALL implement FSM IDLE=0, RAMP_UP=1, RUN=2, RAMP_DOWN=3, DEAD=4.
REQ-017 SHALL run a prescaler only in RAMP_UP, RAMP_DOWN and DEAD, clear it on every state entry, and pulse tick when the count reaches TICK_DIV-1.
REQ-018 SHALL latch target = max(tgtFreq, FREQ_MIN) on start, and in RUN on any tgtFreq change.
REQ-019 IDLE: m3start=0, m3freq=0. cmdStart and no fault -> RAMP_UP next cycle with m3freq=FREQ_MIN, direction=cmdDir, m3start=1.
REQ-020 RAMP_UP: each tick sets m3freq=min(m3freq+STEP, target) using 11-bit arithmetic. -> RUN the cycle after m3freq==target.
REQ-021 RUN: atSpeed=1. target above m3freq -> RAMP_UP. target below m3freq -> RAMP_DOWN with no stop pending.
REQ-022 RUN: cmdDir differing from the latched direction -> RAMP_DOWN with reverse pending.
REQ-023 RAMP_DOWN: each tick sets m3freq=max(m3freq-STEP, floor). Floor = FREQ_MIN when stop or reverse is pending, else target.
REQ-024 RAMP_DOWN at floor: no pending flag -> RUN. Stop or reverse pending -> DEAD.
REQ-025 DEAD: m3start=0 and m3freq=0. After DEAD_TICKS ticks: reverse pending -> RAMP_UP with the new direction; otherwise -> IDLE.
REQ-026 cmdStop in RAMP_UP or RUN SHALL set stop pending and enter RAMP_DOWN next cycle.
REQ-027 cmdStart in RAMP_DOWN SHALL clear stop pending and enter RAMP_UP toward target.
REQ-028 When cmdStop and cmdStart arrive in the same cycle, cmdStop SHALL win.
REQ-029 fault=1 in any state other than IDLE SHALL force DEAD next cycle, m3start=0, and clear reverse pending.
REQ-030 While fault=1, DEAD SHALL not exit.
REQ-031 A non-cmdDir direction change SHALL never reach m3invOrStop while m3start=1.
REQ-032 busy SHALL be 1 in every state except IDLE.
REQ-033 All outputs SHALL be registered, with 1-cycle latency from command to output.

Reset
REQ-034 nReset low SHALL force IDLE asynchronously with m3start=0, m3invOrStop=0, m3freq=0, atSpeed=0, busy=0, state=0, and prescaler, tick count and pending flags all cleared.
REQ-035 Reset mid-ramp SHALL drop m3start immediately. After release, the block SHALL wait for a new cmdStart.

Structure
REQ-036 Shared package motoro301_pkg SHALL hold the state encoding constants and the default parameter values.
REQ-037 SHALL instantiate one sub-module, motoro301_tick_div, the clearable prescaler that produces tick.

Verification
All scenarios use TICK_DIV=4, FREQ_MIN=2, STEP=1, DEAD_TICKS=3.
REQ-038 Start, tgtFreq=6, cmdDir=0 -> m3freq steps 2,3,4,5,6 every 4 cycles, then RUN with atSpeed=1.
REQ-039 cmdStop in RUN at 6 -> m3freq ramps down to 2, then DEAD with m3start=0 for 12 cycles, then IDLE with busy=0.
REQ-040 In RUN at 6, cmdDir=1 -> ramp down to 2, DEAD, then RAMP_UP with m3invOrStop=1; m3invOrStop never changes while m3start=1.
REQ-041 cmdStart+cmdStop in the same cycle while in IDLE -> stays IDLE. fault=1 at m3freq=4 -> next cycle m3start=0, state=4, held until fault=0.
REQ-042 In RUN at 6, tgtFreq=3 -> ramp down to 3 and return to RUN with m3start held 1. tgtFreq=0 on start -> target clamps to 2.
REQ-043 nReset pulse during RAMP_UP -> all outputs 0 asynchronously, IDLE after release.
